// File: rtl/execute_writeback.sv
// execute_writeback: retires execute_add results to the register file through a
// 2-entry in-order buffer, owns the architectural carry flag, and either bypasses
// buffered results to decode or raises a read-after-write hazard.
// Optional feature macro: EXECUTE_WRITEBACK_FORWARD_EN (defined = bypass, undefined = hazard).
// Opecode/width parameters mirror defs_insn.v and can be overridden at instantiation.
module execute_writeback #(
  parameter int LEN_OPECODE = 6,
  parameter int LEN_REG     = 32,
  parameter int LEN_REGADDR = 5,
  parameter logic [LEN_OPECODE-1:0] OPECODE_ADD = 6'd1,
  parameter logic [LEN_OPECODE-1:0] OPECODE_SUB = 6'd2,
  parameter logic [LEN_OPECODE-1:0] OPECODE_ADC = 6'd3,
  parameter logic [LEN_OPECODE-1:0] OPECODE_SBC = 6'd4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [LEN_OPECODE-1:0] ex_opecode,
  input  logic                   ex_wr_en,
  input  logic [LEN_REGADDR-1:0] ex_waddr,
  input  logic [LEN_REG-1:0]     ex_data,
  input  logic                   ex_carry,
  output logic                   carry_flag,
  output logic                   rf_we,
  output logic [LEN_REGADDR-1:0] rf_waddr,
  output logic [LEN_REG-1:0]     rf_wdata,
  input  logic                   rf_ready,
  input  logic [LEN_REGADDR-1:0] rd_addr,
  input  logic [LEN_REGADDR-1:0] rs_addr,
  output logic                   fwd_rd_hit,
  output logic                   fwd_rs_hit,
  output logic [LEN_REG-1:0]     fwd_rd_data,
  output logic [LEN_REG-1:0]     fwd_rs_data,
  output logic                   hazard
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state;
  logic [LEN_REGADDR-1:0] addr0;
  logic [LEN_REGADDR-1:0] addr1;
  logic [LEN_REG-1:0]     data0;
  logic [LEN_REG-1:0]     data1;
  logic                   carry_q;

  logic accept;
  logic push;
  logic pop;
  logic carry_op;
  logic valid0;
  logic valid1;
  logic rd_m0;
  logic rd_m1;
  logic rs_m0;
  logic rs_m1;

  // Slot 0 is always the head (oldest); slot 1 exists only when FULL.
  assign valid0   = (state != EMPTY);
  assign valid1   = (state == FULL);

  assign ex_ready = !rst && (state != FULL);
  assign accept   = ex_valid && ex_ready;
  assign push     = accept && ex_wr_en;

  // rf_we is masked by rst so a pending entry is never written during the reset cycle.
  assign rf_we    = !rst && valid0;
  assign pop      = rf_we && rf_ready;
  assign rf_waddr = addr0;
  assign rf_wdata = data0;

  assign carry_op = (ex_opecode == OPECODE_ADD) || (ex_opecode == OPECODE_SUB) ||
                    (ex_opecode == OPECODE_ADC) || (ex_opecode == OPECODE_SBC);

  assign carry_flag = carry_q;

  // Buffer occupancy FSM plus carry flag; a pop from FULL shifts slot 1 into the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      addr0   <= '0;
      addr1   <= '0;
      data0   <= '0;
      data1   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept && carry_op) begin
        carry_q <= ex_carry;
      end
      case (state)
        EMPTY: begin
          if (push) begin
            addr0 <= ex_waddr;
            data0 <= ex_data;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            addr0 <= ex_waddr;
            data0 <= ex_data;
          end else if (push) begin
            addr1 <= ex_waddr;
            data1 <= ex_data;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            addr0 <= addr1;
            data0 <= data1;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Operand match against each valid entry; register 0 never matches.
  assign rd_m0 = valid0 && (rd_addr != '0) && (addr0 == rd_addr);
  assign rd_m1 = valid1 && (rd_addr != '0) && (addr1 == rd_addr);
  assign rs_m0 = valid0 && (rs_addr != '0) && (addr0 == rs_addr);
  assign rs_m1 = valid1 && (rs_addr != '0) && (addr1 == rs_addr);

`ifdef EXECUTE_WRITEBACK_FORWARD_EN
  // Slot 1 is younger than slot 0, so it takes priority when both match.
  assign fwd_rd_hit  = rd_m0 || rd_m1;
  assign fwd_rs_hit  = rs_m0 || rs_m1;
  assign fwd_rd_data = rd_m1 ? data1 : (rd_m0 ? data0 : '0);
  assign fwd_rs_data = rs_m1 ? data1 : (rs_m0 ? data0 : '0);
  assign hazard      = 1'b0;
`else
  assign fwd_rd_hit  = 1'b0;
  assign fwd_rs_hit  = 1'b0;
  assign fwd_rd_data = '0;
  assign fwd_rs_data = '0;
  assign hazard      = rd_m0 || rd_m1 || rs_m0 || rs_m1;
`endif

endmodule

// File: tb/tb_execute_writeback.sv
// tb_execute_writeback: directed self-checking bench for execute_writeback.
// Inputs change 1 time unit after a rising edge; outputs are checked away from the edge.
module tb_execute_writeback;

  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;
  localparam logic [5:0] OP_ADC = 6'd3;
  localparam logic [5:0] OP_OR  = 6'd5;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_opecode;
  logic        ex_wr_en;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_data;
  logic        ex_carry;
  logic        carry_flag;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready;
  logic [4:0]  rd_addr;
  logic [4:0]  rs_addr;
  logic        fwd_rd_hit;
  logic        fwd_rs_hit;
  logic [31:0] fwd_rd_data;
  logic [31:0] fwd_rs_data;
  logic        hazard;

  int checks;
  int failures;

  execute_writeback dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opecode(ex_opecode),
    .ex_wr_en(ex_wr_en), .ex_waddr(ex_waddr), .ex_data(ex_data), .ex_carry(ex_carry),
    .carry_flag(carry_flag),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .rd_addr(rd_addr), .rs_addr(rs_addr),
    .fwd_rd_hit(fwd_rd_hit), .fwd_rs_hit(fwd_rs_hit),
    .fwd_rd_data(fwd_rd_data), .fwd_rs_data(fwd_rs_data),
    .hazard(hazard)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] op, input logic wr, input logic [4:0] a,
                         input logic [31:0] d, input logic c);
    ex_valid   = 1'b1;
    ex_opecode = op;
    ex_wr_en   = wr;
    ex_waddr   = a;
    ex_data    = d;
    ex_carry   = c;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++; if (ex_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ex_ready got=%b exp=0", ex_ready); end
    checks++; if (carry_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_carry got=%b exp=0", carry_flag); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_rf_bus got=%0d/%h exp=0/0", rf_waddr, rf_wdata); end
    checks++; if (fwd_rd_hit !== 1'b0 || fwd_rs_hit !== 1'b0 || hazard !== 1'b0) begin failures++; $display("[TB] FAIL reset_lookup got=%b%b%b exp=000", fwd_rd_hit, fwd_rs_hit, hazard); end
    checks++; if (fwd_rd_data !== 32'd0 || fwd_rs_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_fwd_data got=%h/%h exp=0/0", fwd_rd_data, fwd_rs_data); end
    rst = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%b exp=1", ex_ready); end
  endtask

  task automatic test_add;
    rf_ready = 1'b1;
    present(OP_ADD, 1'b1, 5'd5, 32'h0000_0004, 1'b0);
    tick;
    ex_valid = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1) begin failures++; $display("[TB] FAIL add_rf_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin failures++; $display("[TB] FAIL add_rf_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'h0000_0004) begin failures++; $display("[TB] FAIL add_rf_wdata got=%h exp=00000004", rf_wdata); end
    checks++; if (carry_flag !== 1'b0) begin failures++; $display("[TB] FAIL add_carry got=%b exp=0", carry_flag); end
    tick;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL add_retired got=%b exp=0", rf_we); end
  endtask

  task automatic test_carry;
    present(OP_ADD, 1'b0, 5'd6, 32'h0000_0000, 1'b1);
    tick;
    present(OP_ADC, 1'b0, 5'd7, 32'h0000_0001, 1'b0);
    #1;
    checks++; if (carry_flag !== 1'b1) begin failures++; $display("[TB] FAIL carry_into_adc got=%b exp=1", carry_flag); end
    tick;
    checks++; if (carry_flag !== 1'b0) begin failures++; $display("[TB] FAIL adc_clears got=%b exp=0", carry_flag); end
    present(OP_SUB, 1'b0, 5'd6, 32'h0000_0000, 1'b1);
    tick;
    present(OP_OR, 1'b0, 5'd6, 32'h0000_0000, 1'b0);
    tick;
    checks++; if (carry_flag !== 1'b1) begin failures++; $display("[TB] FAIL non_carry_op_holds got=%b exp=1", carry_flag); end
    present(OP_ADC, 1'b0, 5'd6, 32'h0000_0000, 1'b0);
    tick;
    ex_valid = 1'b0;
    checks++; if (carry_flag !== 1'b0) begin failures++; $display("[TB] FAIL adc_after_or got=%b exp=0", carry_flag); end
  endtask

  task automatic test_nowrite;
    present(OP_SUB, 1'b0, 5'd9, 32'h0000_0099, 1'b1);
    tick;
    ex_valid = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL nowrite_rf_we got=%b exp=0", rf_we); end
    checks++; if (carry_flag !== 1'b1) begin failures++; $display("[TB] FAIL nowrite_carry got=%b exp=1", carry_flag); end
  endtask

  task automatic test_back_to_back;
    rf_ready = 1'b0;
    present(OP_OR, 1'b1, 5'd1, 32'h0000_0101, 1'b0);
    tick;
    present(OP_OR, 1'b1, 5'd2, 32'h0000_0202, 1'b0);
    #1;
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_one got=%b exp=1", ex_ready); end
    tick;
    present(OP_OR, 1'b1, 5'd3, 32'h0000_0303, 1'b0);
    #1;
    checks++; if (ex_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_full got=%b exp=0", ex_ready); end
    tick;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h0000_0101) begin failures++; $display("[TB] FAIL b2b_stall_head got=%b/%0d/%h exp=1/1/00000101", rf_we, rf_waddr, rf_wdata); end
    rf_ready = 1'b1;
    #1;
    checks++; if (ex_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_comb_ready got=%b exp=0", ex_ready); end
    tick;
    checks++; if (rf_waddr !== 5'd2 || rf_wdata !== 32'h0000_0202) begin failures++; $display("[TB] FAIL b2b_second got=%0d/%h exp=2/00000202", rf_waddr, rf_wdata); end
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_after_pop got=%b exp=1", ex_ready); end
    tick;
    ex_valid = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h0000_0303) begin failures++; $display("[TB] FAIL b2b_third got=%b/%0d/%h exp=1/3/00000303", rf_we, rf_waddr, rf_wdata); end
    tick;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drained got=%b exp=0", rf_we); end
    checks++; if (carry_flag !== 1'b1) begin failures++; $display("[TB] FAIL b2b_carry_held got=%b exp=1", carry_flag); end
  endtask

  task automatic test_bypass;
    rf_ready = 1'b0;
    present(OP_ADD, 1'b1, 5'd4, 32'h0000_0011, 1'b0);
    tick;
    present(OP_ADD, 1'b1, 5'd4, 32'h0000_0022, 1'b1);
    tick;
    ex_valid = 1'b0;
    rd_addr  = 5'd4;
    rs_addr  = 5'd7;
    #1;
`ifdef EXECUTE_WRITEBACK_FORWARD_EN
    checks++; if (fwd_rd_hit !== 1'b1 || fwd_rd_data !== 32'h0000_0022) begin failures++; $display("[TB] FAIL bypass_rd_young got=%b/%h exp=1/00000022", fwd_rd_hit, fwd_rd_data); end
    checks++; if (fwd_rs_hit !== 1'b0 || hazard !== 1'b0) begin failures++; $display("[TB] FAIL bypass_rs_miss got=%b/%b exp=0/0", fwd_rs_hit, hazard); end
`else
    checks++; if (hazard !== 1'b1) begin failures++; $display("[TB] FAIL hazard_rd got=%b exp=1", hazard); end
    checks++; if (fwd_rd_hit !== 1'b0 || fwd_rd_data !== 32'd0) begin failures++; $display("[TB] FAIL no_fwd_rd got=%b/%h exp=0/0", fwd_rd_hit, fwd_rd_data); end
`endif
    rd_addr = 5'd0;
    rs_addr = 5'd4;
    #1;
`ifdef EXECUTE_WRITEBACK_FORWARD_EN
    checks++; if (fwd_rs_hit !== 1'b1 || fwd_rs_data !== 32'h0000_0022) begin failures++; $display("[TB] FAIL bypass_rs_young got=%b/%h exp=1/00000022", fwd_rs_hit, fwd_rs_data); end
`else
    checks++; if (hazard !== 1'b1) begin failures++; $display("[TB] FAIL hazard_rs got=%b exp=1", hazard); end
`endif
    rs_addr = 5'd0;
    #1;
    checks++; if (fwd_rd_hit !== 1'b0 || fwd_rs_hit !== 1'b0 || hazard !== 1'b0) begin failures++; $display("[TB] FAIL reg0_no_hit got=%b%b%b exp=000", fwd_rd_hit, fwd_rs_hit, hazard); end
    checks++; if (carry_flag !== 1'b1) begin failures++; $display("[TB] FAIL bypass_carry got=%b exp=1", carry_flag); end
  endtask

  task automatic test_reset_mid;
    rf_ready = 1'b1;
    rst      = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_no_write got=%b exp=0", rf_we); end
    tick;
    rst = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_rf_we got=%b exp=0", rf_we); end
    checks++; if (carry_flag !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_carry got=%b exp=0", carry_flag); end
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_ready got=%b exp=1", ex_ready); end
    rd_addr = 5'd4;
    #1;
    checks++; if (fwd_rd_hit !== 1'b0 || hazard !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_flushed got=%b/%b exp=0/0", fwd_rd_hit, hazard); end
    tick;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_stays_empty got=%b exp=0", rf_we); end
  endtask

  // Runs each scenario in order and prints the summary.
  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    ex_valid   = 1'b0;
    ex_opecode = '0;
    ex_wr_en   = 1'b0;
    ex_waddr   = '0;
    ex_data    = '0;
    ex_carry   = 1'b0;
    rf_ready   = 1'b0;
    rd_addr    = '0;
    rs_addr    = '0;
    test_reset;
    test_add;
    test_carry;
    test_nowrite;
    test_back_to_back;
    test_bypass;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_writeback.md
# execute_writeback

Pipeline stage between `execute_add` and the register-file write port: accepts the adder's `data_o`/`carry_o` result, owns the architectural carry flag that feeds back into `carry_i`, and retires results in order through a 2-entry buffer. It absorbs register-file back-pressure. It also either bypasses buffered results to the operand-read stage or flags read-after-write hazards.

## Interface
Parameters (from `defs_insn.v`, plus one local):
- LEN_OPECODE, from defs_insn.v, opecode width
- LEN_REG, from defs_insn.v, data width (32)
- OPECODE_ADD / OPECODE_SUB / OPECODE_ADC / OPECODE_SBC, from defs_insn.v, carry-producing opecodes
- LEN_REGADDR, 5, register index width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  execute stage presents a result
- ex_ready  out  1  buffer can accept a result this cycle
- ex_opecode  in  LEN_OPECODE  opecode of the presented result
- ex_wr_en  in  1  result writes a register
- ex_waddr  in  LEN_REGADDR  destination register
- ex_data  in  LEN_REG  result (`execute_add.data_o`)
- ex_carry  in  1  carry out (`execute_add.carry_o`)
- carry_flag  out  1  architectural carry; drives `execute_add.carry_i`
- rf_we  out  1  register-file write request
- rf_waddr  out  LEN_REGADDR  write address
- rf_wdata  out  LEN_REG  write data
- rf_ready  in  1  register file accepts the write this cycle
- rd_addr, rs_addr  in  LEN_REGADDR  operand addresses being read by decode
- fwd_rd_hit, fwd_rs_hit  out  1  bypass valid for rd / rs
- fwd_rd_data, fwd_rs_data  out  LEN_REG  bypass data
- hazard  out  1  operand matches an unretired write that cannot be bypassed

## Operation
- Storage: 2-entry in-order FIFO of {waddr, data}, with count 0/1/2. The states are EMPTY, ONE and FULL.
- Accept: accept = ex_valid && ex_ready. ex_ready = !rst && count != 2.
- Enqueue: an accepted result is enqueued only if ex_wr_en=1. Results with ex_wr_en=0 only update the carry flag.
- Carry flag: on accept with ex_opecode in {ADD, SUB, ADC, SBC}, carry_flag <= ex_carry, stored verbatim with no inversion. Other opecodes and non-accepted cycles hold the flag.
- Retire: rf_we = (count != 0). rf_waddr/rf_wdata come from the head entry. Pop when rf_we && rf_ready.
- Simultaneous push and pop:
  - At ONE: count stays 1; the head advances to the new entry.
  - At EMPTY: push only, because rf_we=0.
  - At FULL: no push, because ex_ready=0.
- Bypass lookup (combinational on state):
  - For each operand, search the entries and select the youngest valid entry whose waddr matches. Hit implies data = that entry's data.
  - Register 0 never hits.
- Reset: count=0, entries invalidated, carry_flag=0, and no write is issued. Reset mid-operation discards pending entries, so no rf write occurs for them.

## Timing
- Reset values: ex_ready=0, carry_flag=0, rf_we=0, rf_waddr=0, rf_wdata=0, fwd_*_hit=0, fwd_*_data=0, hazard=0.
- Accept at edge N: carry_flag is valid after N. This lets a back-to-back ADC/SBC issued in cycle N+1 use it.
- Enqueue at edge N into EMPTY: rf_we=1 in cycle N+1. Minimum latency is 1 cycle.
- rf_ready held low: entries stay put, and rf_we, rf_waddr and rf_wdata stay stable until popped.
- The only combinational paths are the lookup to fwd_*/hazard and count to ex_ready. There is no combinational path from rf_ready to ex_ready.

## Configuration
- EXECUTE_WRITEBACK_FORWARD_EN defined:
  - fwd_*_hit and fwd_*_data operate as described.
  - hazard=0.
- EXECUTE_WRITEBACK_FORWARD_EN undefined:
  - fwd_*_hit=0 and fwd_*_data=0.
  - hazard=1 whenever rd_addr or rs_addr (nonzero) matches any valid entry.
  - Decode must stall on hazard.

## Test plan
- ADD, r5, 1+3, carry 0, rf_ready=1: next cycle rf_we=1, rf_waddr=5, rf_wdata=0x00000004; carry_flag=0.
- ADD 0xffffffff+1 (data 0, carry 1) then ADC the next cycle: carry_flag=1 during the ADC. An ADC result with carry 0 clears it, and a non-carry opecode in between leaves it unchanged.
- rf_ready=0, three back-to-back writes to r1, r2, r3:
  - ex_ready drops after the second accept, and the third is held.
  - With rf_ready=1, writes retire in order r1, r2, r3, one per cycle.
  - Push and pop at ONE keep count=1.
- Entries r4=0x11 (older) and r4=0x22 (younger) buffered, rd_addr=4:
  - With EXECUTE_WRITEBACK_FORWARD_EN: fwd_rd_hit=1, fwd_rd_data=0x22.
  - Without it: hazard=1.
  - rd_addr=0 gives no hit and no hazard.
- Two entries pending, rst=1 for one cycle: afterwards rf_we=0, count=0, carry_flag=0, no write issued, and ex_ready=1 in the first cycle after reset.
- ex_wr_en=0 with SUB carry 1: no rf write, and carry_flag=1.
